// File: rtl/crypto_bridge_pkg.sv
// Shared state encoding and width helpers for the crypto word bridge.
package crypto_bridge_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StLoad = 2'd1;
    localparam state_t StRun  = 2'd2;
    localparam state_t StRead = 2'd3;

    // $clog2 that never returns 0, so a depth-1 pointer still has one bit
    function automatic int unsigned safe_clog2(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned word_lsb(input int unsigned k, input int unsigned n,
                                             input int unsigned w, input bit msw_first);
        return msw_first ? w * (n - 1 - k) : w * k;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registers a level strobe and emits a one-cycle pulse on its 0->1 transition.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic pulse
);

    logic strobe_q;
    logic strobe_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q  <= 1'b0;
            strobe_qq <= 1'b0;
        end else begin
            strobe_q  <= strobe;
            strobe_qq <= strobe_q;
        end
    end

    assign pulse = strobe_q & ~strobe_qq;

endmodule

// File: rtl/crypto_word_bridge.sv
// Packs host words into a wide core block and serialises the core digest back to the host.
module crypto_word_bridge
    import crypto_bridge_pkg::*;
#(
    parameter int unsigned W         = 16,
    parameter int unsigned IN_WORDS  = 50,
    parameter int unsigned OUT_WORDS = 16,
    parameter bit          MSW_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init,
    input  logic                   load,
    input  logic                   fetch,
    input  logic [W-1:0]           idata,
    output logic                   ack,
    output logic [W-1:0]           odata,
    output logic                   busy,
    output logic                   overrun,
    output logic                   core_init,
    output logic                   core_start,
    output logic [W*IN_WORDS-1:0]  core_block,
    input  logic                   core_done,
    input  logic [W*OUT_WORDS-1:0] core_digest
);

    localparam int unsigned IW = safe_clog2(IN_WORDS);
    localparam int unsigned OW = safe_clog2(OUT_WORDS);
    localparam int unsigned BW = safe_clog2(W * IN_WORDS);
    localparam int unsigned DW = safe_clog2(W * OUT_WORDS);

    logic init_ev, load_ev, fetch_ev;
    logic [W-1:0] idata_q;

    state_t                 state_q, state_d;
    logic [IW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [W*IN_WORDS-1:0]  block_q, block_d;
    logic [W*OUT_WORDS-1:0] digest_q, digest_d;
    logic [W-1:0]           odata_q, odata_d;
    logic                   ack_q, ack_d;
    logic                   overrun_q, overrun_d;
    logic                   core_init_q, core_init_d;
    logic                   core_start_q, core_start_d;
    logic [BW-1:0]          wr_lsb;
    logic [DW-1:0]          rd_lsb;

    edge_pulse u_init_edge  (.clk(clk), .rst_n(rst_n), .strobe(init),  .pulse(init_ev));
    edge_pulse u_load_edge  (.clk(clk), .rst_n(rst_n), .strobe(load),  .pulse(load_ev));
    edge_pulse u_fetch_edge (.clk(clk), .rst_n(rst_n), .strobe(fetch), .pulse(fetch_ev));

    assign wr_lsb = BW'(word_lsb(int'(wr_ptr_q), IN_WORDS, W, MSW_FIRST));
    assign rd_lsb = DW'(word_lsb(int'(rd_ptr_q), OUT_WORDS, W, MSW_FIRST));

    always_comb begin
        logic load_taken;
        load_taken   = 1'b0;
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        block_d      = block_q;
        digest_d     = digest_q;
        odata_d      = odata_q;
        overrun_d    = overrun_q;
        ack_d        = 1'b0;
        core_init_d  = 1'b0;
        core_start_d = 1'b0;

        if (init_ev) begin
            state_d     = StIdle;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overrun_d   = 1'b0;
            core_init_d = 1'b1;
            ack_d       = 1'b1;
        end else begin
            if (load_ev) begin
                if (state_q == StIdle || state_q == StLoad) begin
                    block_d[wr_lsb +: W] = idata_q;
                    ack_d                = 1'b1;
                    load_taken           = 1'b1;
                    if (wr_ptr_q == IW'(IN_WORDS - 1)) begin
                        wr_ptr_d     = '0;
                        core_start_d = 1'b1;
                        state_d      = StRun;
                    end else begin
                        wr_ptr_d = wr_ptr_q + IW'(1);
                        state_d  = StLoad;
                    end
                end else begin
                    overrun_d = 1'b1;
                end
            end
            // A fetch in the same cycle as an accepted load is dropped without a flag
            if (fetch_ev && !load_taken) begin
                if (state_q == StRead) begin
                    odata_d = digest_q[rd_lsb +: W];
                    ack_d   = 1'b1;
                    if (rd_ptr_q == OW'(OUT_WORDS - 1)) begin
                        rd_ptr_d = '0;
                        state_d  = StIdle;
                    end else begin
                        rd_ptr_d = rd_ptr_q + OW'(1);
                    end
                end else begin
                    overrun_d = 1'b1;
                end
            end
            if (core_done && state_q == StRun) begin
                digest_d = core_digest;
                rd_ptr_d = '0;
                state_d  = StRead;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            block_q      <= '0;
            digest_q     <= '0;
            odata_q      <= '0;
            ack_q        <= 1'b0;
            overrun_q    <= 1'b0;
            core_init_q  <= 1'b0;
            core_start_q <= 1'b0;
            idata_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            block_q      <= block_d;
            digest_q     <= digest_d;
            odata_q      <= odata_d;
            ack_q        <= ack_d;
            overrun_q    <= overrun_d;
            core_init_q  <= core_init_d;
            core_start_q <= core_start_d;
            idata_q      <= idata;
        end
    end

    assign ack        = ack_q;
    assign odata      = odata_q;
    assign busy       = (state_q == StRun);
    assign overrun    = overrun_q;
    assign core_init  = core_init_q;
    assign core_start = core_start_q;
    assign core_block = block_q;

endmodule
